// File: rtl/ble_verdict_rx_pkg.sv
// Shared constants and state encodings for the BLE verdict receive path.
package ble_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] TYPE_VERDICT = 8'h01;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    TYPE,
    LEN,
    PAYLOAD,
    CSUM
  } parser_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/ble_verdict_rx_if.sv
// Link between the BLE module's UART TX line and the verdict/error strobes for the classifier.
interface ble_verdict_rx_if;

  logic       ble_uart_rx_in;
  logic       verdict_valid_out;
  logic [7:0] verdict_data_out;
  logic       err_frame_out;
  logic       err_checksum_out;
  logic       err_timeout_out;

  modport master (
    output ble_uart_rx_in,
    input  verdict_valid_out,
    input  verdict_data_out,
    input  err_frame_out,
    input  err_checksum_out,
    input  err_timeout_out
  );

  modport slave (
    input  ble_uart_rx_in,
    output verdict_valid_out,
    output verdict_data_out,
    output err_frame_out,
    output err_checksum_out,
    output err_timeout_out
  );

endinterface

// File: rtl/ble_verdict_rx_uart_byte_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampler, one-cycle byte and framing-error strobes.
module uart_byte_rx
  import ble_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  uart_state_t   r_state;
  uart_state_t   w_nextState;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_rxPrev;
  logic [CW-1:0] r_baudCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_byteValid;
  logic          r_frameErr;
  logic          w_fall;
  logic          w_tick;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= i_rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  assign w_fall = r_rxPrev & ~r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_nextState = START;
      START:   if (w_tick) w_nextState = r_sync2 ? IDLE : DATA;
      DATA:    if (w_tick && (r_bitIdx == 3'd7)) w_nextState = STOP;
      STOP:    if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Start bit is checked half a bit in; every later sample is a full bit apart.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      START:       w_tick = (r_baudCnt == HALF_LAST);
      DATA, STOP:  w_tick = (r_baudCnt == FULL_LAST);
      default:     w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baudCnt   <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
      if ((r_state == IDLE) || w_tick) r_baudCnt <= '0;
      else                             r_baudCnt <= r_baudCnt + CW'(1);
      if (r_state == START) r_bitIdx <= '0;
      if ((r_state == DATA) && w_tick) begin
        r_shift  <= {r_sync2, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if ((r_state == STOP) && w_tick) begin
        r_byteValid <= r_sync2;
        r_frameErr  <= ~r_sync2;
      end
    end
  end

  assign o_byte_data  = r_shift;
  assign o_byte_valid = r_byteValid;
  assign o_frame_err  = r_frameErr;

endmodule

// File: rtl/ble_verdict_rx.sv
// BLE verdict receiver: UART bytes parsed as SYNC/TYPE/LEN/PAYLOAD/CSUM packets, verdicts strobed out.
module ble_verdict_rx
  import ble_pkg::*;
#(
  parameter int BAUD_DIV       = 868,
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  ble_verdict_rx_if.slave  bus
);

  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  logic [7:0]    w_byteData;
  logic          w_byteValid;
  logic          w_frameErr;

  parser_state_t r_state;
  parser_state_t w_nextState;
  logic [7:0]    r_type;
  logic [7:0]    r_len;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_acc;
  logic [7:0]    r_payload [MAX_LEN];
  logic [TW-1:0] r_toCnt;
  logic          r_verdictValid;
  logic [7:0]    r_verdictData;
  logic          r_errCsum;
  logic          r_errTimeout;
  logic          w_csumByte;
  logic          w_csumMatch;
  logic          w_verdictFire;
  logic          w_csumErr;
  logic          w_timeout;

  uart_byte_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .i_clk        (clk_in),
    .i_rst        (rst_in),
    .i_rx         (bus.ble_uart_rx_in),
    .o_byte_data  (w_byteData),
    .o_byte_valid (w_byteValid),
    .o_frame_err  (w_frameErr)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= WAIT_SYNC;
    else        r_state <= w_nextState;
  end

  // A framing error or a stalled packet always drops back to hunting for SYNC.
  always_comb begin
    w_nextState = r_state;
    if (w_frameErr || w_timeout) begin
      w_nextState = WAIT_SYNC;
    end else if (w_byteValid) begin
      case (r_state)
        WAIT_SYNC: if (w_byteData == SYNC_BYTE) w_nextState = TYPE;
        TYPE:      w_nextState = LEN;
        LEN: begin
          if (w_byteData > MAX_LEN_B)     w_nextState = WAIT_SYNC;
          else if (w_byteData == 8'd0)    w_nextState = CSUM;
          else                            w_nextState = PAYLOAD;
        end
        PAYLOAD:   if (8'(r_idx) == (r_len - 8'd1)) w_nextState = CSUM;
        CSUM:      w_nextState = WAIT_SYNC;
        default:   w_nextState = WAIT_SYNC;
      endcase
    end
  end

  always_comb begin
    w_csumByte    = w_byteValid && (r_state == CSUM);
    w_csumMatch   = (w_byteData == r_acc);
    w_verdictFire = w_csumByte && w_csumMatch && (r_type == TYPE_VERDICT) && (r_len != 8'd0);
    w_csumErr     = w_csumByte && !w_csumMatch;
    w_timeout     = (r_state != WAIT_SYNC) && !w_byteValid && !w_frameErr && (r_toCnt == TO_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_type         <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      r_toCnt        <= '0;
      r_verdictValid <= 1'b0;
      r_verdictData  <= '0;
      r_errCsum      <= 1'b0;
      r_errTimeout   <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) r_payload[k] <= '0;
    end else begin
      r_verdictValid <= w_verdictFire;
      r_errCsum      <= w_csumErr;
      r_errTimeout   <= w_timeout;
      if (w_verdictFire) r_verdictData <= r_payload[0];
      if ((r_state == WAIT_SYNC) || w_byteValid || w_frameErr || w_timeout) r_toCnt <= '0;
      else                                                                  r_toCnt <= r_toCnt + TW'(1);
      if (w_byteValid) begin
        case (r_state)
          TYPE: begin
            r_type <= w_byteData;
            r_acc  <= w_byteData;
          end
          LEN: begin
            r_len <= w_byteData;
            r_acc <= r_acc + w_byteData;
            r_idx <= '0;
          end
          PAYLOAD: begin
            r_payload[r_idx] <= w_byteData;
            r_acc            <= r_acc + w_byteData;
            r_idx            <= r_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.verdict_valid_out = r_verdictValid;
  assign bus.verdict_data_out  = r_verdictData;
  assign bus.err_frame_out     = w_frameErr;
  assign bus.err_checksum_out  = r_errCsum;
  assign bus.err_timeout_out   = r_errTimeout;

endmodule
